fpu_req_arbiter: RTL and testbench

//  Shares one FPU instance between NUM_REQ requesters. Round-robin arbitration,

---
 rtl/fpu_req_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_fpu_req_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_req_arbiter.sv
// Round-robin front end that shares one FPU between NUM_REQ requesters:
// grants, captures operands, sequences start/done and returns results with timeout.
module fpu_req_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 32,
    parameter int OP_W        = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*OP_W-1:0]   req_opcode,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]         resp_result,
    output logic                      resp_error,
    output logic                      busy,
    output logic                      fpu_start,
    output logic [OP_W-1:0]           fpu_opcode,
    output logic [DATA_W-1:0]         fpu_a,
    output logic [DATA_W-1:0]         fpu_b,
    input  logic [DATA_W-1:0]         fpu_result,
    input  logic                      fpu_done
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_RESP  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [IDX_W-1:0]    ptr_r, ptr_nxt_s;
    logic [IDX_W-1:0]    gnt_r, gnt_nxt_s;
    logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
    logic [NUM_REQ-1:0]  ack_r, ack_nxt_s;
    logic [NUM_REQ-1:0]  resp_valid_r, resp_valid_nxt_s;
    logic [DATA_W-1:0]   resp_result_r, resp_result_nxt_s;
    logic                resp_error_r, resp_error_nxt_s;
    logic                busy_r, busy_nxt_s;
    logic                fpu_start_r, fpu_start_nxt_s;
    logic [OP_W-1:0]     fpu_opcode_r, fpu_opcode_nxt_s;
    logic [DATA_W-1:0]   fpu_a_r, fpu_a_nxt_s;
    logic [DATA_W-1:0]   fpu_b_r, fpu_b_nxt_s;

    logic                pick_found_s;
    logic [IDX_W-1:0]    pick_idx_s;
    logic [IDX_W-1:0]    cand_s;

    // Round-robin search: first requester at or after ptr, wrapping.
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        cand_s       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = IDX_W'((int'(ptr_r) + k) % NUM_REQ);
            if (!pick_found_s && req[cand_s]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = cand_s;
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_nxt_s       = state_r;
        ptr_nxt_s         = ptr_r;
        gnt_nxt_s         = gnt_r;
        cnt_nxt_s         = cnt_r;
        ack_nxt_s         = '0;
        resp_valid_nxt_s  = '0;
        resp_result_nxt_s = resp_result_r;
        resp_error_nxt_s  = resp_error_r;
        fpu_start_nxt_s   = fpu_start_r;
        fpu_opcode_nxt_s  = fpu_opcode_r;
        fpu_a_nxt_s       = fpu_a_r;
        fpu_b_nxt_s       = fpu_b_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_found_s) begin
                    fpu_opcode_nxt_s      = req_opcode[int'(pick_idx_s)*OP_W +: OP_W];
                    fpu_a_nxt_s           = req_a[int'(pick_idx_s)*DATA_W +: DATA_W];
                    fpu_b_nxt_s           = req_b[int'(pick_idx_s)*DATA_W +: DATA_W];
                    gnt_nxt_s             = pick_idx_s;
                    ptr_nxt_s             = (pick_idx_s == IDX_W'(NUM_REQ-1)) ? '0
                                                                            : pick_idx_s + IDX_W'(1);
                    cnt_nxt_s             = '0;
                    ack_nxt_s[pick_idx_s] = 1'b1;
                    fpu_start_nxt_s       = 1'b1;
                    state_nxt_s           = ST_RUN;
                end else begin
                    fpu_start_nxt_s = 1'b0;
                end
            end
            ST_RUN: begin
                // A done arriving on the timeout cycle still counts as success.
                if (fpu_done) begin
                    resp_result_nxt_s       = fpu_result;
                    resp_error_nxt_s        = 1'b0;
                    resp_valid_nxt_s[gnt_r] = 1'b1;
                    fpu_start_nxt_s         = 1'b0;
                    state_nxt_s             = ST_RESP;
                end else if (cnt_r == CNT_W'(TIMEOUT_CYC-1)) begin
                    resp_result_nxt_s       = '0;
                    resp_error_nxt_s        = 1'b1;
                    resp_valid_nxt_s[gnt_r] = 1'b1;
                    fpu_start_nxt_s         = 1'b0;
                    state_nxt_s             = ST_RESP;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_RESP: begin
                fpu_start_nxt_s = 1'b0;
                state_nxt_s     = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Wait out a lingering done so it is never mistaken for the next result.
                fpu_start_nxt_s = 1'b0;
                if (!fpu_done) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                fpu_start_nxt_s = 1'b0;
                state_nxt_s     = ST_IDLE;
            end
        endcase
        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            ptr_r         <= '0;
            gnt_r         <= '0;
            cnt_r         <= '0;
            ack_r         <= '0;
            resp_valid_r  <= '0;
            resp_result_r <= '0;
            resp_error_r  <= 1'b0;
            busy_r        <= 1'b0;
            fpu_start_r   <= 1'b0;
            fpu_opcode_r  <= '0;
            fpu_a_r       <= '0;
            fpu_b_r       <= '0;
        end else begin
            state_r       <= state_nxt_s;
            ptr_r         <= ptr_nxt_s;
            gnt_r         <= gnt_nxt_s;
            cnt_r         <= cnt_nxt_s;
            ack_r         <= ack_nxt_s;
            resp_valid_r  <= resp_valid_nxt_s;
            resp_result_r <= resp_result_nxt_s;
            resp_error_r  <= resp_error_nxt_s;
            busy_r        <= busy_nxt_s;
            fpu_start_r   <= fpu_start_nxt_s;
            fpu_opcode_r  <= fpu_opcode_nxt_s;
            fpu_a_r       <= fpu_a_nxt_s;
            fpu_b_r       <= fpu_b_nxt_s;
        end
    end

    assign ack         = ack_r;
    assign resp_valid  = resp_valid_r;
    assign resp_result = resp_result_r;
    assign resp_error  = resp_error_r;
    assign busy        = busy_r;
    assign fpu_start   = fpu_start_r;
    assign fpu_opcode  = fpu_opcode_r;
    assign fpu_a       = fpu_a_r;
    assign fpu_b       = fpu_b_r;

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// Scoreboard bench for fpu_req_arbiter: directed requests against an FPU model
// that answers from a table of hand-computed single-precision results.
module tb_fpu_req_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;
    localparam int OP_W    = 4;
    localparam int TO_CYC  = 16;
    localparam int LAT     = 5;
    localparam int NVEC    = 6;

    localparam logic [3:0]  V_OP [NVEC] = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
    localparam logic [31:0] V_A  [NVEC] = '{32'h3F800000, 32'h40000000, 32'h40A00000,
                                           32'h40000000, 32'h40C00000, 32'h41200000};
    localparam logic [31:0] V_B  [NVEC] = '{32'h40000000, 32'h40400000, 32'h3F800000,
                                           32'h40400000, 32'h40000000, 32'h41A00000};
    localparam logic [31:0] V_R  [NVEC] = '{32'h40400000, 32'h40A00000, 32'h40800000,
                                           32'h40C00000, 32'h40400000, 32'h41F00000};

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*OP_W-1:0]   req_opcode;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ-1:0]        ack;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [DATA_W-1:0]         resp_result;
    logic                      resp_error;
    logic                      busy;
    logic                      fpu_start;
    logic [OP_W-1:0]           fpu_opcode;
    logic [DATA_W-1:0]         fpu_a;
    logic [DATA_W-1:0]         fpu_b;
    logic [DATA_W-1:0]         fpu_result;
    logic                      fpu_done;

    fpu_req_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .OP_W(OP_W), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk(clk), .rst(rst), .req(req), .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
        .ack(ack), .resp_valid(resp_valid), .resp_result(resp_result), .resp_error(resp_error),
        .busy(busy), .fpu_start(fpu_start), .fpu_opcode(fpu_opcode), .fpu_a(fpu_a), .fpu_b(fpu_b),
        .fpu_result(fpu_result), .fpu_done(fpu_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  idx;
        logic [31:0] res;
        logic        err;
    } resp_t;

    int    ack_q[$];
    resp_t resp_q[$];
    int    len_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    ack_seen = 0;
    int    run_len = 0;
    int    hold = 0;
    bit    fpu_never = 1'b0;
    logic [NUM_REQ-1:0] drop_on_ack;

    function automatic logic [31:0] fpu_lookup(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < NVEC; i++)
            if (V_OP[i] == op && V_A[i] == a && V_B[i] == b) return V_R[i];
        return 32'hDEADBEEF;
    endfunction

    function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
        for (int i = 0; i < NUM_REQ; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // FPU model: done LAT-1 sampled start cycles after start rises, then lingers `hold` cycles.
    int m_cnt = 0;
    int hold_cnt = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt <= 0; hold_cnt <= 0; fpu_done <= 1'b0; fpu_result <= 32'h0;
        end else if (fpu_start) begin
            hold_cnt <= 0;
            if (!fpu_done && !fpu_never) begin
                m_cnt <= m_cnt + 1;
                if (m_cnt + 1 == LAT - 1) begin
                    fpu_done   <= 1'b1;
                    fpu_result <= fpu_lookup(fpu_opcode, fpu_a, fpu_b);
                end
            end
        end else begin
            m_cnt <= 0;
            if (fpu_done) begin
                if (hold_cnt < hold) hold_cnt <= hold_cnt + 1;
                else                 fpu_done <= 1'b0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents ack, resp_valid or a finished start pulse.
    initial forever begin
        @(negedge clk or posedge rst);
        if (rst) begin
            run_len = 0;
        end else begin
            if (ack != '0) begin
                check("ack_onehot", 64'($countones(ack)), 64'd1);
                if (ack_q.size() == 0) fail("ack_unexpected");
                else check("ack_idx", 64'(onehot_idx(ack)), 64'(ack_q.pop_front()));
            end
            if (resp_valid != '0) begin
                check("resp_onehot", 64'($countones(resp_valid)), 64'd1);
                if (resp_q.size() == 0) fail("resp_unexpected");
                else begin
                    resp_t e;
                    e = resp_q.pop_front();
                    check("resp_idx", 64'(onehot_idx(resp_valid)), 64'(e.idx));
                    check("resp_result", 64'(resp_result), 64'(e.res));
                    check("resp_error", 64'(resp_error), 64'(e.err));
                end
            end
            if (fpu_start) begin
                run_len++;
            end else if (run_len > 0) begin
                if (len_q.size() == 0) fail("start_len_unexpected");
                else check("start_len", 64'(run_len), 64'(len_q.pop_front()));
                run_len = 0;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (ack != '0) ack_seen++;
        for (int i = 0; i < NUM_REQ; i++)
            if (ack[i] && drop_on_ack[i]) req[i] = 1'b0;
    endtask

    task automatic set_req(input int idx, input int vec);
        req_opcode[idx*OP_W +: OP_W]     = V_OP[vec];
        req_a[idx*DATA_W +: DATA_W]      = V_A[vec];
        req_b[idx*DATA_W +: DATA_W]      = V_B[vec];
        req[idx]                         = 1'b1;
    endtask

    task automatic expect_op(input int idx, input int vec, input bit to, input bit with_resp);
        resp_t e;
        ack_q.push_back(idx);
        if (with_resp) begin
            e.idx = 2'(idx);
            e.res = to ? 32'h0 : V_R[vec];
            e.err = to;
            resp_q.push_back(e);
            len_q.push_back(to ? TO_CYC : LAT);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((busy || ack_q.size() != 0 || resp_q.size() != 0) && n < budget);
        if (busy || ack_q.size() != 0 || resp_q.size() != 0) fail(name);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int n, fall_t, ack_t;
        bit seen_done;
        req = '0; req_opcode = '0; req_a = '0; req_b = '0;
        drop_on_ack = '1;
        rst = 1'b1;
        tick(); tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_fpu_start", 64'(fpu_start), 64'd0);
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_result", 64'(resp_result), 64'd0);
        check("rst_fpu_a", 64'(fpu_a), 64'd0);
        rst = 1'b0;
        tick();

        // 1: single request, 1-cycle accept, start held LAT cycles
        set_req(0, 0); expect_op(0, 0, 1'b0, 1'b1);
        tick();
        check("t1_ack_latency", 64'(ack), 64'h1);
        check("t1_start_latency", 64'(fpu_start), 64'd1);
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_fpu_a", 64'(fpu_a), 64'(V_A[0]));
        check("t1_fpu_b", 64'(fpu_b), 64'(V_B[0]));
        wait_idle("t1_idle_timeout", 60);
        repeat (3) tick();
        check("t1_result_held", 64'(resp_result), 64'h40400000);

        // 2: all four, drop on own ack -> 0,1,2,3
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, i);
        for (int i = 0; i < NUM_REQ; i++) expect_op(i, i, 1'b0, 1'b1);
        wait_idle("t2_idle_timeout", 200);

        // 3: requesters 1 and 3 held -> 1,3,1,3
        do_reset();
        drop_on_ack = 4'b0101;
        set_req(1, 1); set_req(3, 2);
        expect_op(1, 1, 1'b0, 1'b1); expect_op(3, 2, 1'b0, 1'b1);
        expect_op(1, 1, 1'b0, 1'b1); expect_op(3, 2, 1'b0, 1'b1);
        ack_seen = 0; n = 0;
        while (ack_seen < 4 && n < 200) begin tick(); n++; end
        if (ack_seen < 4) fail("t3_ack_timeout");
        req = '0;
        drop_on_ack = '1;
        wait_idle("t3_idle_timeout", 200);

        // 4: FPU never answers -> timeout response, then a normal request
        fpu_never = 1'b1;
        set_req(2, 4); expect_op(2, 4, 1'b1, 1'b1);
        n = 0;
        while (resp_q.size() != 0 && n < 100) begin tick(); n++; end
        if (resp_q.size() != 0) fail("t4_timeout_resp_missing");
        fpu_never = 1'b0;
        set_req(0, 5); expect_op(0, 5, 1'b0, 1'b1);
        wait_idle("t4_idle_timeout", 100);

        // 5: reset during RUN discards the operation and resets ptr
        set_req(1, 1); expect_op(1, 1, 1'b0, 1'b0);
        tick(); tick(); tick();
        #2 rst = 1'b1;
        #1;
        check("t5_start_async_low", 64'(fpu_start), 64'd0);
        check("t5_busy_async_low", 64'(busy), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, i);
        for (int i = 0; i < NUM_REQ; i++) expect_op(i, i, 1'b0, 1'b1);
        wait_idle("t5_idle_timeout", 200);

        // 6: lingering done blocks the next grant until DRAIN sees it low
        hold = 3;
        set_req(0, 0); expect_op(0, 0, 1'b0, 1'b1);
        tick();
        set_req(2, 1); expect_op(2, 1, 1'b0, 1'b1);
        seen_done = 1'b0; fall_t = -1; ack_t = -1; n = 0;
        while (ack_t < 0 && n < 100) begin
            tick(); n++;
            if (fpu_done) seen_done = 1'b1;
            else if (seen_done && fall_t < 0) fall_t = cyc;
            if (ack[2]) ack_t = cyc;
        end
        if (ack_t < 0) fail("t6_ack_timeout");
        else check("t6_ack_after_done_fall", 64'(ack_t - fall_t), 64'd2);
        hold = 0;
        wait_idle("t6_idle_timeout", 100);

        check("end_ack_q_empty", 64'(ack_q.size()), 64'd0);
        check("end_len_q_empty", 64'(len_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
